datapath_ctrl: RTL and testbench

DATAPATH_CTRL -- requirements
Module: datapath_ctrl

---
 rtl/ctrl_pkg.sv | 35 +++
 rtl/datapath_ctrl_if.sv | 33 +++
 rtl/ctrl_decode.sv | 17 +
 rtl/datapath_ctrl.sv | 122 ++++++++++++
 tb/tb_datapath_ctrl.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared state, opcode and ALUop encodings for datapath_ctrl (CTRL_ILLEGAL_TRAP_EN adds ERROR)
package ctrl_pkg;

  `ifdef CTRL_ILLEGAL_TRAP_EN
  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_ALU, S_WRITE_REG, S_WRITE_IMM, S_ERROR
  } state_e;
  `else
  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_ALU, S_WRITE_REG, S_WRITE_IMM
  } state_e;
  `endif

  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_ALU    = 3'b101;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_CMP     = 2'b01;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [1:0]  sh;
    logic [2:0]  rm;
    logic [15:0] sximm8;
  } ir_fields_t;

endpackage

// File: rtl/datapath_ctrl_if.sv
// rtl/datapath_ctrl_if.sv - instruction/handshake inputs and datapath strobes of datapath_ctrl
interface datapath_ctrl_if;
  logic [15:0] in;
  logic        load;
  logic        s;
  logic        w;
  logic        err;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        vsel;
  logic        loada;
  logic        loadb;
  logic        asel;
  logic        bsel;
  logic        loadc;
  logic        loads;
  logic        write;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] datapath_in;

  modport master (
    output in, load, s,
    input  w, err, readnum, writenum, vsel, loada, loadb, asel, bsel,
           loadc, loads, write, shift, ALUop, datapath_in
  );

  modport slave (
    input  in, load, s,
    output w, err, readnum, writenum, vsel, loada, loadb, asel, bsel,
           loadc, loads, write, shift, ALUop, datapath_in
  );
endinterface

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational IR field split and im8 sign extension
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [15:0] ir_i,
  output ir_fields_t  fields_o
);

  assign fields_o.opcode = ir_i[15:13];
  assign fields_o.op     = ir_i[12:11];
  assign fields_o.rn     = ir_i[10:8];
  assign fields_o.rd     = ir_i[7:5];
  assign fields_o.sh     = ir_i[4:3];
  assign fields_o.rm     = ir_i[2:0];
  assign fields_o.sximm8 = {{8{ir_i[7]}}, ir_i[7:0]};

endmodule

// File: rtl/datapath_ctrl.sv
// rtl/datapath_ctrl.sv - instruction register and Moore control FSM for the datapath
// CTRL_ILLEGAL_TRAP_EN: illegal opcodes trap in ERROR until reset instead of returning to WAIT.
module datapath_ctrl
  import ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  datapath_ctrl_if.slave bus
);

  logic [15:0] ir_q, ir_d;
  state_e      state_q, state_d;
  ir_fields_t  f;
  logic        is_mov_imm, is_mov_reg, is_alu, is_cmp;

  ctrl_decode u_decode (
    .ir_i     (ir_q),
    .fields_o (f)
  );

  assign is_mov_imm = (f.opcode == OPC_MOV) && (f.op == OP_MOV_IMM);
  assign is_mov_reg = (f.opcode == OPC_MOV) && (f.op == OP_MOV_REG);
  assign is_alu     = (f.opcode == OPC_ALU);
  assign is_cmp     = is_alu && (f.op == OP_CMP);

  // IR captures in every state so DECODE sees a word loaded on the start edge
  assign ir_d = bus.load ? bus.in : ir_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    bus.w           = 1'b0;
    bus.err         = 1'b0;
    bus.readnum     = '0;
    bus.writenum    = '0;
    bus.vsel        = 1'b0;
    bus.loada       = 1'b0;
    bus.loadb       = 1'b0;
    bus.asel        = 1'b0;
    bus.bsel        = 1'b0;
    bus.loadc       = 1'b0;
    bus.loads       = 1'b0;
    bus.write       = 1'b0;
    bus.shift       = '0;
    bus.ALUop       = '0;
    bus.datapath_in = '0;

    case (state_q)
      S_WAIT: begin
        bus.w = 1'b1;
        if (bus.s) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_mov_imm)      state_d = S_WRITE_IMM;
        else if (is_mov_reg) state_d = S_GET_B;
        else if (is_alu)     state_d = S_GET_A;
        else begin
          `ifdef CTRL_ILLEGAL_TRAP_EN
          state_d = S_ERROR;
          `else
          state_d = S_WAIT;
          `endif
        end
      end
      S_GET_A: begin
        bus.readnum = f.rn;
        bus.loada   = 1'b1;
        state_d     = S_GET_B;
      end
      S_GET_B: begin
        bus.readnum = f.rm;
        bus.loadb   = 1'b1;
        state_d     = S_ALU;
      end
      S_ALU: begin
        bus.shift = f.sh;
        // MOV reg passes B through the adder with A forced to zero
        if (is_mov_reg) begin
          bus.asel  = 1'b1;
          bus.ALUop = ALU_ADD;
        end else begin
          bus.ALUop = f.op;
        end
        if (is_cmp) begin
          bus.loads = 1'b1;
          state_d   = S_WAIT;
        end else begin
          bus.loadc = 1'b1;
          state_d   = S_WRITE_REG;
        end
      end
      S_WRITE_REG: begin
        bus.writenum = f.rd;
        bus.write    = 1'b1;
        state_d      = S_WAIT;
      end
      S_WRITE_IMM: begin
        bus.writenum    = f.rn;
        bus.vsel        = 1'b1;
        bus.write       = 1'b1;
        bus.datapath_in = f.sximm8;
        state_d         = S_WAIT;
      end
      `ifdef CTRL_ILLEGAL_TRAP_EN
      S_ERROR: begin
        bus.err = 1'b1;
      end
      `endif
      default: state_d = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_datapath_ctrl.sv
// tb/tb_datapath_ctrl.sv - scoreboard bench for datapath_ctrl (honours CTRL_ILLEGAL_TRAP_EN)
module tb_datapath_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  datapath_ctrl_if bus ();

  datapath_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam logic [7:0] ST_VSEL  = 8'h80;
  localparam logic [7:0] ST_LOADA = 8'h40;
  localparam logic [7:0] ST_LOADB = 8'h20;
  localparam logic [7:0] ST_ASEL  = 8'h10;
  localparam logic [7:0] ST_LOADC = 8'h04;
  localparam logic [7:0] ST_LOADS = 8'h02;
  localparam logic [7:0] ST_WRITE = 8'h01;

  int total = 0;
  int bad = 0;
  logic [35:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {w, err, readnum, writenum, vsel..write, shift, ALUop, datapath_in}
  function automatic logic [35:0] vec(input logic w, input logic e, input logic [2:0] rn,
                                      input logic [2:0] wn, input logic [7:0] stb,
                                      input logic [1:0] sh, input logic [1:0] aop,
                                      input logic [15:0] dp);
    return {w, e, rn, wn, stb, sh, aop, dp};
  endfunction

  function automatic logic [35:0] observe();
    return {bus.w, bus.err, bus.readnum, bus.writenum,
            {bus.vsel, bus.loada, bus.loadb, bus.asel, bus.bsel, bus.loadc, bus.loads, bus.write},
            bus.shift, bus.ALUop, bus.datapath_in};
  endfunction

  function automatic logic [35:0] wait_vec();
    return vec(1'b1, 1'b0, 3'd0, 3'd0, 8'h00, 2'd0, 2'd0, 16'h0000);
  endfunction

  // Expected outputs for each cycle starting with the one right after the start edge
  task automatic push_expected(input logic [15:0] ir);
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh;
    logic [15:0] sx;
    opc = ir[15:13]; op = ir[12:11]; rn = ir[10:8]; rd = ir[7:5]; sh = ir[4:3]; rm = ir[2:0];
    sx = {{8{ir[7]}}, ir[7:0]};
    exp_q.push_back(vec(1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 2'd0, 2'd0, 16'h0));
    if (opc == 3'b110 && op == 2'b10) begin
      exp_q.push_back(vec(1'b0, 1'b0, 3'd0, rn, ST_VSEL | ST_WRITE, 2'd0, 2'd0, sx));
      exp_q.push_back(wait_vec());
      exp_q.push_back(wait_vec());
    end else if (opc == 3'b110 && op == 2'b00) begin
      exp_q.push_back(vec(1'b0, 1'b0, rm, 3'd0, ST_LOADB, 2'd0, 2'd0, 16'h0));
      exp_q.push_back(vec(1'b0, 1'b0, 3'd0, 3'd0, ST_ASEL | ST_LOADC, sh, 2'b00, 16'h0));
      exp_q.push_back(vec(1'b0, 1'b0, 3'd0, rd, ST_WRITE, 2'd0, 2'd0, 16'h0));
      exp_q.push_back(wait_vec());
    end else if (opc == 3'b101) begin
      exp_q.push_back(vec(1'b0, 1'b0, rn, 3'd0, ST_LOADA, 2'd0, 2'd0, 16'h0));
      exp_q.push_back(vec(1'b0, 1'b0, rm, 3'd0, ST_LOADB, 2'd0, 2'd0, 16'h0));
      if (op == 2'b01) begin
        exp_q.push_back(vec(1'b0, 1'b0, 3'd0, 3'd0, ST_LOADS, sh, op, 16'h0));
      end else begin
        exp_q.push_back(vec(1'b0, 1'b0, 3'd0, 3'd0, ST_LOADC, sh, op, 16'h0));
        exp_q.push_back(vec(1'b0, 1'b0, 3'd0, rd, ST_WRITE, 2'd0, 2'd0, 16'h0));
      end
      exp_q.push_back(wait_vec());
    end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
      exp_q.push_back(vec(1'b0, 1'b1, 3'd0, 3'd0, 8'h00, 2'd0, 2'd0, 16'h0));
      exp_q.push_back(vec(1'b0, 1'b1, 3'd0, 3'd0, 8'h00, 2'd0, 2'd0, 16'h0));
`else
      exp_q.push_back(wait_vec());
      exp_q.push_back(wait_vec());
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input string tag, input int max_pops);
    int n = 0;
    while (exp_q.size() > 0 && n < max_pops) begin
      check_eq($sformatf("%s_c%0d", tag, n), 64'(observe()), 64'(exp_q.pop_front()));
      n++;
      if (exp_q.size() > 0 && n < max_pops) step();
    end
  endtask

  // Drives s at the next edge; the word is loaded on the same edge when same_edge=1
  task automatic run_instr(input string tag, input logic [15:0] ir, input bit same_edge);
    if (!same_edge) begin
      bus.in = ir; bus.load = 1'b1; bus.s = 1'b0;
      step();
      bus.load = 1'b0;
      check_eq({tag, "_loaded_wait"}, 64'(observe()), 64'(wait_vec()));
    end
    bus.in = ir; bus.load = same_edge; bus.s = 1'b1;
    push_expected(ir);
    step();
    bus.load = 1'b0; bus.s = 1'b0; bus.in = 16'h0000;
    drain(tag, 16);
  endtask

  initial begin
    bus.in = 16'h0000; bus.load = 1'b0; bus.s = 1'b0;
    rst_n = 1'b0;
    step();
    check_eq("reset_outputs", 64'(observe()), 64'(wait_vec()));
    check_eq("reset_ir", 64'(dut.ir_q), 64'h0);
    rst_n = 1'b1;
    step();

    run_instr("mov_imm_neg", 16'hD0FD, 1'b1);
    run_instr("add_lsl", 16'hA148, 1'b1);
    run_instr("cmp", 16'hAB04, 1'b1);
    run_instr("mov_reg", 16'hC0A6, 1'b1);
    run_instr("and_sep_load", 16'hB395, 1'b0);
    run_instr("mvn", 16'hB8E7, 1'b1);
    run_instr("mov_imm_pos", 16'hD47F, 1'b0);

    // Reset while in ALU of an ADD
    bus.in = 16'hA148; bus.load = 1'b1; bus.s = 1'b1;
    push_expected(16'hA148);
    step();
    bus.load = 1'b0; bus.s = 1'b0;
    drain("add_pre_reset", 4);
    exp_q.delete();
    rst_n = 1'b0;
    step();
    check_eq("mid_reset_outputs", 64'(observe()), 64'(wait_vec()));
    check_eq("mid_reset_ir", 64'(dut.ir_q), 64'h0);
    rst_n = 1'b1;
    step();

    run_instr("illegal", 16'hE000, 1'b1);
`ifdef CTRL_ILLEGAL_TRAP_EN
    bus.s = 1'b1;
    step();
    bus.s = 1'b0;
    check_eq("trap_s_ignored", 64'(observe()),
             64'(vec(1'b0, 1'b1, 3'd0, 3'd0, 8'h00, 2'd0, 2'd0, 16'h0)));
    step();
    check_eq("trap_hold", 64'(observe()),
             64'(vec(1'b0, 1'b1, 3'd0, 3'd0, 8'h00, 2'd0, 2'd0, 16'h0)));
    rst_n = 1'b0;
    step();
    check_eq("trap_reset", 64'(observe()), 64'(wait_vec()));
    rst_n = 1'b1;
    step();
`endif
    run_instr("after_illegal_add", 16'hA148, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
